// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state, time type and seconds limit for the stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef logic [5:0] time_t;
  localparam time_t SEC_MAX = 6'd59;
endpackage

// File: rtl/digit_counter.sv
// digit_counter: modulo-(MAX+1) counter with enable, sync clear and carry-out
import stopwatch_pkg::*;
module digit_counter #(
  parameter time_t MAX = SEC_MAX
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  output time_t q,
  output logic  carry
);
  assign carry = en && q == MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= carry ? '0 : q + 6'd1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM driving a seconds/minutes counter chain
import stopwatch_pkg::*;
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_running,
  output logic       o_wrap
);
  state_t state, state_next;
  logic count_en, sec_carry, min_carry;
  always_comb begin
    state_next = i_clear ? IDLE : i_start_stop ? (state == RUN ? PAUSE : RUN) : state;
    count_en = state == RUN && i_tick && !i_clear;
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      o_running <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      state <= state_next;
      o_running <= state_next == RUN;
      o_wrap <= min_carry;
    end
  digit_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(i_clk), .rst(i_reset), .clr(i_clear), .en(count_en), .q(o_sec), .carry(sec_carry)
  );
  digit_counter #(.MAX(time_t'(MAX_MIN))) u_min (
    .clk(i_clk), .rst(i_reset), .clr(i_clear), .en(sec_carry), .q(o_min), .carry(min_carry)
  );
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random checks against a total-seconds reference model
module tb_stopwatch_ctrl;
  localparam int MM = 1;
  logic i_clk = 0, i_reset = 0, i_tick = 0, i_start_stop = 0, i_clear = 0;
  logic [5:0] o_sec, o_min;
  logic o_running, o_wrap;
  int cmp = 0, bad = 0;
  int t = 0;
  int mode = 0;
  bit ew = 0;
  always #5 i_clk = ~i_clk;
  stopwatch_ctrl #(.MAX_MIN(MM)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .o_sec(o_sec), .o_min(o_min), .o_running(o_running), .o_wrap(o_wrap)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, ".sec"}, 32'(o_sec), t % 60);
    chk({tag, ".min"}, 32'(o_min), t / 60);
    chk({tag, ".running"}, 32'(o_running), (mode == 1) ? 1 : 0);
    chk({tag, ".wrap"}, 32'(o_wrap), ew ? 1 : 0);
  endtask
  task automatic model_reset();
    t = 0;
    mode = 0;
    ew = 0;
  endtask
  task automatic step(string tag, bit tk, bit ss, bit cl);
    i_tick = tk;
    i_start_stop = ss;
    i_clear = cl;
    @(posedge i_clk);
    ew = 0;
    if (cl) begin
      t = 0;
      mode = 0;
    end else begin
      if (mode == 1 && tk) begin
        t++;
        if (t == (MM + 1) * 60) begin
          t = 0;
          ew = 1;
        end
      end
      if (ss) mode = (mode == 1) ? 2 : 1;
    end
    #1;
    check_all(tag);
    i_tick = 0;
    i_start_stop = 0;
    i_clear = 0;
  endtask
  task automatic ticks(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 1, 0, 0);
  endtask
  initial begin
    #1 i_reset = 1;
    #1 check_all("reset_async");
    #3;
    for (int i = 0; i < 6; i++) begin
      i_tick = ~i_tick;
      @(negedge i_clk);
      check_all("reset_hold");
    end
    i_tick = 0;
    i_reset = 0;
    step("idle_tick", 1, 0, 0);
    step("start", 0, 1, 0);
    ticks("count", 61);
    chk("count_min", 32'(o_min), 1);
    chk("count_sec", 32'(o_sec), 1);
    chk("count_run", 32'(o_running), 1);
    step("clr", 0, 0, 1);
    step("start", 0, 1, 0);
    ticks("pre_pause", 5);
    step("pause", 0, 1, 0);
    ticks("paused", 10);
    chk("pause_sec", 32'(o_sec), 5);
    step("resume", 0, 1, 0);
    step("resume_tick", 1, 0, 0);
    chk("resume_sec", 32'(o_sec), 6);
    step("clr", 0, 0, 1);
    step("start", 0, 1, 0);
    ticks("to10", 10);
    step("all3", 1, 1, 1);
    chk("all3_sec", 32'(o_sec), 0);
    chk("all3_run", 32'(o_running), 0);
    step("start", 0, 1, 0);
    ticks("to3", 3);
    step("tick_ss", 1, 1, 0);
    chk("tick_ss_sec", 32'(o_sec), 4);
    step("paused_tick", 1, 0, 0);
    step("idle_ss_tick", 1, 1, 1);
    step("idle_tick_ss", 1, 1, 0);
    chk("idle_tick_ss_sec", 32'(o_sec), 0);
    step("clr", 0, 0, 1);
    step("start", 0, 1, 0);
    ticks("to159", 119);
    chk("pre_wrap_min", 32'(o_min), 1);
    chk("pre_wrap_sec", 32'(o_sec), 59);
    step("wrap", 1, 0, 0);
    chk("wrap_pulse", 32'(o_wrap), 1);
    step("post_wrap", 0, 0, 0);
    chk("wrap_drop", 32'(o_wrap), 0);
    chk("wrap_run", 32'(o_running), 1);
    step("clr", 0, 0, 1);
    step("start", 0, 1, 0);
    ticks("to20", 20);
    #3 i_reset = 1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge i_clk);
    i_reset = 0;
    step("post_rst_tick", 1, 0, 0);
    for (int i = 0; i < 600; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 199) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 59, giving the highest minute value before wrap.
REQ-002 The block SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port i_tick  input  1  one-cycle seconds tick, driven by the roll-over output of the modulo-k counter stage.
REQ-005 The block SHALL have port i_start_stop  input  1  one-cycle command pulse that toggles run/pause.
REQ-006 The block SHALL have port i_clear  input  1  one-cycle command pulse that zeroes the time and returns to IDLE.
REQ-007 The block SHALL have port o_sec  output  6  registered seconds value, 0..59.
REQ-008 The block SHALL have port o_min  output  6  registered minutes value, 0..MAX_MIN.
REQ-009 The block SHALL have port o_running  output  1  high while the FSM is in RUN.
REQ-010 The block SHALL have port o_wrap  output  1  one-cycle pulse when the time wraps from MAX_MIN:59 to 00:00.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-012 FSM transitions SHALL be:
- IDLE to RUN on i_start_stop.
- RUN to PAUSE on i_start_stop.
- PAUSE to RUN on i_start_stop.
- Any state to IDLE on i_clear.
REQ-013 i_clear SHALL have priority over i_start_stop and i_tick in the same cycle.
REQ-014 On i_clear, the next edge SHALL set o_sec=0, o_min=0 and state IDLE.
REQ-015 Counting SHALL happen only when the current state is RUN and i_tick=1.
REQ-016 Each counted tick SHALL increment o_sec by 1, with the new value visible after that same rising edge (latency 1).
REQ-017 When o_sec=59 and a tick is counted, o_sec SHALL become 0 and o_min SHALL increment by 1.
REQ-018 When o_min=MAX_MIN, o_sec=59 and a tick is counted, both SHALL become 0, o_wrap SHALL pulse high for that next cycle, and the state SHALL remain RUN.
REQ-019 If i_tick and i_start_stop are both high while in RUN, the tick SHALL be counted and the state SHALL become PAUSE.
REQ-020 If i_tick and i_start_stop are both high while in PAUSE or IDLE, the tick SHALL be ignored and the state SHALL become RUN.
REQ-021 Ticks arriving in IDLE or PAUSE SHALL leave o_sec and o_min unchanged.
REQ-022 o_running SHALL be a registered decode of the state, so it is high in the cycle after entry to RUN.
REQ-023 o_wrap SHALL be registered and high for exactly one cycle per wrap.
REQ-024 Counters SHALL never hold values outside their ranges; the seconds counter is 6-bit and compared against 59.

Reset
REQ-025 While i_reset=1, the block SHALL hold state IDLE, o_sec=0, o_min=0, o_running=0 and o_wrap=0, regardless of i_clk.
REQ-026 Assertion of i_reset mid-count SHALL take effect immediately, without waiting for a clock edge.
REQ-027 Release of i_reset SHALL leave the block in IDLE awaiting i_start_stop.

Structure
REQ-028 A shared package stopwatch_pkg SHALL hold:
- the state enum (IDLE, RUN, PAUSE);
- the constant SEC_MAX=59;
- the 6-bit time type.
REQ-029 The block SHALL instantiate two copies of a sub-module digit_counter: a modulo-N counter with enable, synchronous clear and carry-out, one for seconds and one for minutes.
REQ-030 In the chain, the seconds carry-out SHALL enable the minutes counter, and the minutes carry-out SHALL drive o_wrap.

Verification
REQ-031 Reset scenario: hold i_reset high for 3 time units, then toggle i_tick freely -> o_sec=0, o_min=0, o_running=0 throughout.
REQ-032 Counting scenario: i_start_stop pulse, then 61 ticks -> o_min=1, o_sec=1, o_running=1.
REQ-033 Pause scenario: in RUN at 00:05, pulse i_start_stop, then 10 ticks -> time stays 00:05; a further i_start_stop and 1 tick -> 00:06.
REQ-034 Wrap scenario: with MAX_MIN=1, from 01:59 apply 1 tick -> 00:00, o_wrap high for 1 cycle, o_running stays 1.
REQ-035 Simultaneous-input scenario: in RUN at 00:10, drive i_tick, i_start_stop and i_clear together -> 00:00 and IDLE; then i_tick with i_start_stop in RUN at 00:03 -> 00:04 and PAUSE.
REQ-036 Async reset scenario: assert i_reset between clock edges at 00:20 -> outputs zero before the next rising edge.
